wb_reg_bridge: RTL and testbench

WB_REG_BRIDGE -- requirements
Module: wb_reg_bridge

---
 rtl/wb_reg_bridge.sv | 119 +++++++++++
 tb/tb_wb_reg_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_bridge.sv
// Wishbone slave to 8-bit register-core bridge: one byte lane per transfer,
// registered outputs, optional wait timeout and a one-cycle delayed interrupt.
module wb_reg_bridge #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int REG_AW  = 3,
   parameter int TIMEOUT = 16
) (
   input  logic                clk_i,
   input  logic                nrst_i,
   input  logic [ADDR_W-1:0]   adr_i,
   input  logic [DATA_W-1:0]   dat_i,
   output logic [DATA_W-1:0]   dat_o,
   input  logic                we_i,
   input  logic [DATA_W/8-1:0] sel_i,
   input  logic                stb_i,
   input  logic                cyc_i,
   output logic                ack_o,
   output logic                err_o,
   output logic                intr_o,
   output logic [REG_AW-1:0]   reg_adr_o,
   output logic [7:0]          reg_wdat_o,
   output logic                reg_we_o,
   output logic                reg_re_o,
   input  logic [7:0]          reg_rdat_i,
   input  logic                reg_rdy_i,
   input  logic                core_intr_i
);

   localparam int SEL_W = DATA_W / 8;
   localparam int LB    = (DATA_W == 32) ? 2 : (DATA_W == 16) ? 1 : 0;
   localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, ERR} state_t;

   state_t              state, state_nx;
   logic [CW-1:0]       cnt, cnt_nx;
   logic [1:0]          lane;
   logic                sel_ok, timeout_hit, accept, busy;
   logic [7:0]          wbyte;
   logic                we_q, we_q_d;
   logic [DATA_W-1:0]   dat_d;
   logic [REG_AW-1:0]   adr_d;
   logic [7:0]          wdat_d;
   logic                ack_d, err_d, rwe_d, rre_d;

   always_comb begin
      lane = 2'd0;
      if (LB == 2)      lane = adr_i[1:0];
      else if (LB == 1) lane = {1'b0, adr_i[0]};
   end

   assign sel_ok      = (sel_i == (SEL_W'(1) << lane));
   assign wbyte       = 8'(dat_i >> {lane, 3'b000});
   assign busy        = (state == REQ) || (state == WAIT);
   assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

   // Abort by the master outranks rdy, and rdy outranks the timeout.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (cyc_i && stb_i) state_nx = sel_ok ? REQ : ERR;
         REQ, WAIT: begin
            if (!cyc_i)          state_nx = IDLE;
            else if (reg_rdy_i)  state_nx = ACK;
            else if (timeout_hit) state_nx = ERR;
            else                 state_nx = WAIT;
         end
         ACK, ERR:  state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
      accept = (state == IDLE) && (state_nx == REQ);
      cnt_nx = cnt;
      if (accept) cnt_nx = '0;
      else if (busy && !reg_rdy_i && (cnt != '1)) cnt_nx = cnt + 1'b1;
   end

   always_comb begin
      ack_d  = (state_nx == ACK);
      err_d  = (state_nx == ERR);
      rwe_d  = accept && we_i;
      rre_d  = accept && !we_i;
      adr_d  = accept ? adr_i[REG_AW-1:0] : reg_adr_o;
      wdat_d = accept ? wbyte : reg_wdat_o;
      we_q_d = accept ? we_i : we_q;
      dat_d  = dat_o;
      if (busy && (state_nx == ACK) && !we_q) dat_d = {SEL_W{reg_rdat_i}};
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         dat_o      <= '0;
         ack_o      <= 1'b0;
         err_o      <= 1'b0;
         intr_o     <= 1'b0;
         reg_adr_o  <= '0;
         reg_wdat_o <= '0;
         reg_we_o   <= 1'b0;
         reg_re_o   <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         we_q       <= we_q_d;
         dat_o      <= dat_d;
         ack_o      <= ack_d;
         err_o      <= err_d;
         intr_o     <= core_intr_i;
         reg_adr_o  <= adr_d;
         reg_wdat_o <= wdat_d;
         reg_we_o   <= rwe_d;
         reg_re_o   <= rre_d;
      end
   end

endmodule

// File: tb/tb_wb_reg_bridge.sv
// Directed bench for wb_reg_bridge: default, TIMEOUT=4 and DATA_W=8 instances
// share one stimulus bus; read data is checked through an expected queue.
module tb_wb_reg_bridge;

   logic        clk_i = 1'b0;
   logic        nrst_i;
   logic [31:0] adr, dat;
   logic [3:0]  sel;
   logic        we, stb, cyc;
   logic [7:0]  reg_rdat;
   logic        reg_rdy, core_intr;

   logic [31:0] dat_a, dat_t;
   logic [7:0]  dat_b;
   logic        ack_a, err_a, intr_a, rwe_a, rre_a;
   logic        ack_t, err_t, intr_t, rwe_t, rre_t;
   logic        ack_b, err_b, intr_b, rwe_b, rre_b;
   logic [2:0]  radr_a, radr_t, radr_b;
   logic [7:0]  wdat_a, wdat_t, wdat_b;

   int total = 0;
   int bad   = 0;
   int n;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   always #5 clk_i = ~clk_i;

   wb_reg_bridge dut_a (
      .clk_i(clk_i), .nrst_i(nrst_i), .adr_i(adr), .dat_i(dat), .dat_o(dat_a),
      .we_i(we), .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack_a), .err_o(err_a),
      .intr_o(intr_a), .reg_adr_o(radr_a), .reg_wdat_o(wdat_a), .reg_we_o(rwe_a),
      .reg_re_o(rre_a), .reg_rdat_i(reg_rdat), .reg_rdy_i(reg_rdy), .core_intr_i(core_intr)
   );

   wb_reg_bridge #(.TIMEOUT(4)) dut_t (
      .clk_i(clk_i), .nrst_i(nrst_i), .adr_i(adr), .dat_i(dat), .dat_o(dat_t),
      .we_i(we), .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack_t), .err_o(err_t),
      .intr_o(intr_t), .reg_adr_o(radr_t), .reg_wdat_o(wdat_t), .reg_we_o(rwe_t),
      .reg_re_o(rre_t), .reg_rdat_i(reg_rdat), .reg_rdy_i(reg_rdy), .core_intr_i(core_intr)
   );

   wb_reg_bridge #(.DATA_W(8), .ADDR_W(8)) dut_b (
      .clk_i(clk_i), .nrst_i(nrst_i), .adr_i(adr[7:0]), .dat_i(dat[7:0]), .dat_o(dat_b),
      .we_i(we), .sel_i(sel[0:0]), .stb_i(stb), .cyc_i(cyc), .ack_o(ack_b), .err_o(err_b),
      .intr_o(intr_b), .reg_adr_o(radr_b), .reg_wdat_o(wdat_b), .reg_we_o(rwe_b),
      .reg_re_o(rre_b), .reg_rdat_i(reg_rdat), .reg_rdy_i(reg_rdy), .core_intr_i(core_intr)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input logic w);
      adr = a; sel = s; dat = d; we = w; cyc = 1'b1; stb = 1'b1;
   endtask

   task automatic release_bus();
      cyc = 1'b0; stb = 1'b0;
   endtask

   // Ticks until dut_a answers, at most limit edges; n is the edges taken.
   task automatic wait_resp_a(input int limit, output int cnt);
      cnt = 0;
      while (!(ack_a || err_a) && cnt < limit) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst_i = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
      reg_rdat = '0; reg_rdy = 1'b0; core_intr = 1'b0;

      // reset values
      repeat (3) tick();
      check("rst_dat", dat_a, 32'h0);
      check("rst_ack", ack_a, 0);
      check("rst_err", err_a, 0);
      check("rst_intr", intr_a, 0);
      check("rst_adr", radr_a, 0);
      check("rst_wdat", wdat_a, 0);
      check("rst_we", rwe_a, 0);
      check("rst_re", rre_a, 0);
      nrst_i = 1'b1;

      // write lane 3, accepted on the first edge after release
      drive(32'h3, 4'b1000, 32'hA500_0000, 1'b1);
      reg_rdy = 1'b1;
      tick();
      check("wr_we", rwe_a, 1);
      check("wr_re", rre_a, 0);
      check("wr_adr", radr_a, 3);
      check("wr_wdat", wdat_a, 8'hA5);
      check("wr_ack_early", ack_a, 0);
      tick();
      check("wr_ack", ack_a, 1);
      check("wr_we_once", rwe_a, 0);
      release_bus();
      reg_rdy = 1'b0;
      tick();
      check("wr_ack_once", ack_a, 0);

      // read lane 1, rdy arrives in cycle 3
      drive(32'h5, 4'b0010, 32'h0, 1'b0);
      reg_rdat = 8'h60;
      exp_q.push_back(32'h6060_6060);
      tick();
      check("rd_re", rre_a, 1);
      check("rd_we", rwe_a, 0);
      check("rd_adr", radr_a, 5);
      tick();
      check("rd_re_once", rre_a, 0);
      check("rd_dat_hold", dat_a, 32'h0);
      tick();
      check("rd_no_ack", ack_a, 0);
      reg_rdy = 1'b1;
      wait_resp_a(20, n);
      check("rd_lat", n, 1);
      check("rd_ack", ack_a, 1);
      check("rd_err", err_a, 0);
      exp_v = exp_q.pop_front();
      check("rd_dat", dat_a, exp_v);
      release_bus();
      reg_rdy = 1'b0;
      reg_rdat = 8'h11;
      tick();
      check("rd_ack_once", ack_a, 0);
      check("rd_dat_keep", dat_a, 32'h6060_6060);

      // illegal byte selects
      drive(32'h1, 4'b0011, 32'h0, 1'b1);
      tick();
      check("bad_sel_err", err_a, 1);
      check("bad_sel_ack", ack_a, 0);
      check("bad_sel_we", rwe_a, 0);
      check("bad_sel_re", rre_a, 0);
      release_bus();
      tick();
      check("bad_sel_err_once", err_a, 0);
      drive(32'h2, 4'b0001, 32'h0, 1'b0);
      tick();
      check("lane_miss_err", err_a, 1);
      check("lane_miss_re", rre_a, 0);
      release_bus();
      tick();

      // master drops cyc in WAIT, then a normal read
      drive(32'h6, 4'b0100, 32'h0, 1'b0);
      reg_rdat = 8'hEE;
      tick();
      check("abort_re", rre_a, 1);
      tick();
      release_bus();
      reg_rdy = 1'b1;
      tick();
      check("abort_ack", ack_a, 0);
      check("abort_err", err_a, 0);
      check("abort_dat", dat_a, 32'h6060_6060);
      reg_rdy = 1'b0;
      tick();
      check("abort_ack2", ack_a, 0);
      drive(32'h2, 4'b0100, 32'h0, 1'b0);
      reg_rdat = 8'h3C;
      reg_rdy = 1'b1;
      exp_q.push_back(32'h3C3C_3C3C);
      tick();
      check("rd2_re", rre_a, 1);
      check("rd2_adr", radr_a, 2);
      tick();
      check("rd2_ack", ack_a, 1);
      exp_v = exp_q.pop_front();
      check("rd2_dat", dat_a, exp_v);
      release_bus();
      reg_rdy = 1'b0;
      tick();

      // stb held: high address bits ignored, second transfer after an IDLE cycle
      drive(32'hFFFF_FFF9, 4'b0010, 32'h0000_7E00, 1'b1);
      reg_rdy = 1'b1;
      tick();
      check("b2b_we", rwe_a, 1);
      check("b2b_adr", radr_a, 1);
      check("b2b_wdat", wdat_a, 8'h7E);
      tick();
      check("b2b_ack1", ack_a, 1);
      tick();
      check("b2b_idle_ack", ack_a, 0);
      check("b2b_idle_we", rwe_a, 0);
      tick();
      check("b2b_we2", rwe_a, 1);
      tick();
      check("b2b_ack2", ack_a, 1);
      release_bus();
      reg_rdy = 1'b0;
      tick();

      // reset pulse in WAIT clears every output at once
      drive(32'h4, 4'b0001, 32'h0, 1'b0);
      tick();
      check("rstw_re", rre_a, 1);
      tick();
      #2;
      nrst_i = 1'b0;
      #1;
      check("rstw_dat", dat_a, 32'h0);
      check("rstw_adr", radr_a, 0);
      check("rstw_ack", ack_a, 0);
      check("rstw_err", err_a, 0);
      release_bus();
      reg_rdy = 1'b1;
      tick();
      nrst_i = 1'b1;
      tick();
      check("rstw_post_ack", ack_a, 0);
      check("rstw_post_err", err_a, 0);
      tick();
      check("rstw_post_ack2", ack_a, 0);

      // TIMEOUT=4 instance: rdy held low gives err in cycle 5 only
      reg_rdy = 1'b0;
      drive(32'h0, 4'b0001, 32'h0000_0042, 1'b1);
      tick();
      check("to_we", rwe_t, 1);
      for (int c = 2; c <= 4; c++) begin
         tick();
         check($sformatf("to_noerr_c%0d", c), err_t, 0);
      end
      tick();
      check("to_err", err_t, 1);
      check("to_ack", ack_t, 0);
      release_bus();
      tick();
      check("to_err_once", err_t, 0);
      tick();

      // rdy in the timeout cycle wins
      drive(32'h0, 4'b0001, 32'h0000_0042, 1'b1);
      tick();
      tick();
      tick();
      tick();
      reg_rdy = 1'b1;
      check("to_race_pre", err_t, 0);
      tick();
      check("to_race_ack", ack_t, 1);
      check("to_race_err", err_t, 0);
      release_bus();
      reg_rdy = 1'b0;
      tick();
      tick();

      // 8-bit instance read
      drive(32'h7, 4'b0001, 32'h0, 1'b0);
      reg_rdat = 8'h9D;
      reg_rdy = 1'b1;
      exp_q.push_back(32'h0000_009D);
      tick();
      check("b8_re", rre_b, 1);
      check("b8_adr", radr_b, 7);
      tick();
      check("b8_ack", ack_b, 1);
      exp_v = exp_q.pop_front();
      check("b8_dat", {24'h0, dat_b}, exp_v);
      release_bus();
      reg_rdy = 1'b0;
      tick();

      // interrupt passthrough
      core_intr = 1'b1;
      #1;
      check("intr_pre", intr_a, 0);
      tick();
      check("intr_rise_a", intr_a, 1);
      check("intr_rise_b", intr_b, 1);
      core_intr = 1'b0;
      tick();
      check("intr_fall", intr_a, 0);

      check("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
